// File: rtl/boss_ctrl.sv
// Boss behaviour sequencer: target arbitration with aggro hysteresis, frame-tick
// driven chase/windup/attack/cooldown phases, enrage and death flags.
module boss_ctrl #(
  parameter int unsigned WINDUP_FRAMES   = 30,
  parameter int unsigned ATTACK_FRAMES   = 10,
  parameter int unsigned COOLDOWN_FRAMES = 60,
  parameter int unsigned ATTACK_RANGE    = 150,
  parameter int unsigned ENRAGE_HP       = 30,
  parameter int unsigned AGGRO_HYST      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [1:0]  game_active,
  input  logic [6:0]  boss_hp,
  input  logic [11:0] boss_x,
  input  logic [11:0] char_x,
  input  logic [11:0] player_2_x,
  input  logic [3:0]  class_aggro,
  input  logic [3:0]  player_2_aggro,
  input  logic        player_2_data_valid,
  output logic        target_sel,
  output logic [11:0] target_x,
  output logic        move_en,
  output logic [2:0]  boss_state,
  output logic        attack_start,
  output logic        attack_active,
  output logic        enraged
);

  localparam int unsigned CNT_W        = 7;
  localparam int unsigned POS_W        = 12;
  localparam int unsigned AGGRO_SUM_W  = 5;
  localparam int unsigned WINDUP_ENR   = ((WINDUP_FRAMES >> 1) == 0) ? 1 : (WINDUP_FRAMES >> 1);
  localparam int unsigned COOLDOWN_ENR = ((COOLDOWN_FRAMES >> 1) == 0) ? 1 : (COOLDOWN_FRAMES >> 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHASE    = 3'd1,
    S_WINDUP   = 3'd2,
    S_ATTACK   = 3'd3,
    S_COOLDOWN = 3'd4,
    S_DEAD     = 3'd5
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_target_sel;
  logic [POS_W-1:0]   r_target_x;
  logic               r_move_en;
  logic               r_attack_start;
  logic               r_attack_active;
  logic               r_enraged;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_sel_nxt;
  logic               w_start_nxt;
  logic               w_enr_nxt;

  logic               w_fight;
  logic               w_hp_zero;
  logic               w_enr_cond;
  logic [3:0]         w_cur_aggro;
  logic [3:0]         w_oth_aggro;
  logic               w_switch;
  logic               w_arb_sel;
  logic [POS_W-1:0]   w_arb_x;
  logic [POS_W-1:0]   w_dist;
  logic [CNT_W-1:0]   w_windup_load;
  logic [CNT_W-1:0]   w_cooldown_load;

  assign w_fight    = (game_active == 2'b01);
  assign w_hp_zero  = (boss_hp == 7'd0);
  assign w_enr_cond = w_fight && !w_hp_zero && (boss_hp <= 7'(ENRAGE_HP));

  // Hysteresis compare in 5 bits so 15 + margin cannot wrap into a false switch
  assign w_cur_aggro = r_target_sel ? player_2_aggro : class_aggro;
  assign w_oth_aggro = r_target_sel ? class_aggro : player_2_aggro;
  assign w_switch    = (AGGRO_SUM_W'(w_oth_aggro)) >=
                       (AGGRO_SUM_W'(w_cur_aggro) + AGGRO_SUM_W'(AGGRO_HYST));
  assign w_arb_sel   = player_2_data_valid ? (w_switch ? ~r_target_sel : r_target_sel) : 1'b0;
  assign w_arb_x     = w_arb_sel ? player_2_x : char_x;
  assign w_dist      = (boss_x >= w_arb_x) ? (boss_x - w_arb_x) : (w_arb_x - boss_x);

  assign w_windup_load   = r_enraged ? CNT_W'(WINDUP_ENR - 1)   : CNT_W'(WINDUP_FRAMES - 1);
  assign w_cooldown_load = r_enraged ? CNT_W'(COOLDOWN_ENR - 1) : CNT_W'(COOLDOWN_FRAMES - 1);

  // Next-state, counter, target and flag logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_target_sel;
    w_start_nxt = 1'b0;
    w_enr_nxt   = r_enraged | w_enr_cond;
    if (!w_fight) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_enr_nxt   = 1'b0;
    end else begin
      if (frame_tick && !player_2_data_valid) begin
        w_sel_nxt = 1'b0;
      end
      if (w_hp_zero && (r_state != S_IDLE)) begin
        w_state_nxt = S_DEAD;
      end else if (frame_tick) begin
        unique case (r_state)
          S_IDLE: begin
            if (!w_hp_zero) w_state_nxt = S_CHASE;
          end
          S_CHASE: begin
            w_sel_nxt = w_arb_sel;
            if (w_dist <= POS_W'(ATTACK_RANGE)) begin
              w_state_nxt = S_WINDUP;
              w_cnt_nxt   = w_windup_load;
            end
          end
          S_WINDUP: begin
            if (r_cnt == '0) begin
              w_state_nxt = S_ATTACK;
              w_cnt_nxt   = CNT_W'(ATTACK_FRAMES - 1);
              w_start_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
          S_ATTACK: begin
            if (r_cnt == '0) begin
              w_state_nxt = S_COOLDOWN;
              w_cnt_nxt   = w_cooldown_load;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
          S_COOLDOWN: begin
            if (r_cnt == '0) begin
              w_state_nxt = S_CHASE;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
          S_DEAD: w_state_nxt = S_DEAD;
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_target_sel    <= 1'b0;
      r_target_x      <= '0;
      r_move_en       <= 1'b0;
      r_attack_start  <= 1'b0;
      r_attack_active <= 1'b0;
      r_enraged       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_target_sel    <= w_sel_nxt;
      r_target_x      <= w_sel_nxt ? player_2_x : char_x;
      r_move_en       <= (w_state_nxt == S_CHASE);
      r_attack_start  <= w_start_nxt;
      r_attack_active <= (w_state_nxt == S_ATTACK);
      r_enraged       <= w_enr_nxt;
    end
  end

  assign target_sel    = r_target_sel;
  assign target_x      = r_target_x;
  assign move_en       = r_move_en;
  assign boss_state    = r_state;
  assign attack_start  = r_attack_start;
  assign attack_active = r_attack_active;
  assign enraged       = r_enraged;

endmodule

// File: tb/tb_boss_ctrl.sv
// Directed self-checking bench for boss_ctrl with hand-computed expectations.
module tb_boss_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic [1:0]  game_active;
  logic [6:0]  boss_hp;
  logic [11:0] boss_x;
  logic [11:0] char_x;
  logic [11:0] player_2_x;
  logic [3:0]  class_aggro;
  logic [3:0]  player_2_aggro;
  logic        player_2_data_valid;
  logic        target_sel;
  logic [11:0] target_x;
  logic        move_en;
  logic [2:0]  boss_state;
  logic        attack_start;
  logic        attack_active;
  logic        enraged;

  int n_tests = 0;
  int n_fail  = 0;

  boss_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_tick          (frame_tick),
    .game_active         (game_active),
    .boss_hp             (boss_hp),
    .boss_x              (boss_x),
    .char_x              (char_x),
    .player_2_x          (player_2_x),
    .class_aggro         (class_aggro),
    .player_2_aggro      (player_2_aggro),
    .player_2_data_valid (player_2_data_valid),
    .target_sel          (target_sel),
    .target_x            (target_x),
    .move_en             (move_en),
    .boss_state          (boss_state),
    .attack_start        (attack_start),
    .attack_active       (attack_active),
    .enraged             (enraged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; game_active = 2'b00; boss_hp = 7'd0;
    boss_x = 12'd0; char_x = 12'd0; player_2_x = 12'd0;
    class_aggro = 4'd0; player_2_aggro = 4'd0; player_2_data_valid = 1'b0;
    clks(3);
    check("rst_state", boss_state, 0);
    check("rst_move", move_en, 0);
    check("rst_tx", target_x, 0);
    rst = 1'b1;

    // Basic phase timing, p2 absent
    game_active = 2'b01; boss_hp = 7'd100; boss_x = 12'd400; char_x = 12'd500;
    clks(1);
    check("idle_no_tick", boss_state, 0);
    tick();
    check("chase", boss_state, 1);
    check("chase_move", move_en, 1);
    check("chase_tx", target_x, 500);
    tick();
    check("windup", boss_state, 2);
    check("windup_move", move_en, 0);
    ticks(29);
    check("windup_29", boss_state, 2);
    check("no_start_29", attack_start, 0);
    tick();
    check("attack", boss_state, 3);
    check("attack_start", attack_start, 1);
    check("attack_active", attack_active, 1);
    clks(1);
    check("start_1clk", attack_start, 0);
    ticks(9);
    check("attack_9", attack_active, 1);
    tick();
    check("cooldown", boss_state, 4);
    check("cd_active", attack_active, 0);
    char_x = 12'd1000;
    ticks(59);
    check("cooldown_59", boss_state, 4);
    tick();
    check("back_chase", boss_state, 1);

    // Aggro hysteresis
    player_2_data_valid = 1'b1; player_2_x = 12'd2000;
    class_aggro = 4'd5; player_2_aggro = 4'd6;
    tick();
    check("aggro_margin1", target_sel, 0);
    check("aggro_stay_chase", boss_state, 1);
    player_2_aggro = 4'd7;
    tick();
    check("aggro_switch", target_sel, 1);
    check("aggro_tx", target_x, 2000);
    player_2_x = 12'd450;
    tick();
    check("p2_windup", boss_state, 2);
    class_aggro = 4'd9;
    tick();
    check("frozen_windup", target_sel, 1);
    ticks(28);
    tick();
    check("p2_attack", boss_state, 3);
    ticks(10);
    check("p2_cooldown", boss_state, 4);
    check("frozen_cd", target_sel, 1);
    class_aggro = 4'd5;

    // p2 drop forces target back to player 1 even in COOLDOWN
    player_2_data_valid = 1'b0;
    clks(2);
    check("drop_wait_tick", target_sel, 1);
    tick();
    check("drop_sel", target_sel, 0);
    check("drop_tx", target_x, 1000);
    check("drop_state", boss_state, 4);
    ticks(58);
    check("cd_still", boss_state, 4);
    tick();
    check("cd_to_chase", boss_state, 1);

    // Range boundary
    boss_x = 12'd100; char_x = 12'd251;
    tick();
    check("range_151", boss_state, 1);
    char_x = 12'd250;
    tick();
    check("range_150", boss_state, 2);

    // Enrage halves windup/cooldown
    game_active = 2'b10;
    clks(1);
    check("not_fight_idle", boss_state, 0);
    game_active = 2'b01; boss_hp = 7'd30;
    clks(1);
    check("enraged_set", enraged, 1);
    ticks(2);
    check("enr_windup", boss_state, 2);
    ticks(14);
    check("enr_windup_14", boss_state, 2);
    tick();
    check("enr_attack", boss_state, 3);
    ticks(9);
    check("enr_attack_9", boss_state, 3);
    tick();
    check("enr_cooldown", boss_state, 4);
    ticks(29);
    check("enr_cd_29", boss_state, 4);
    tick();
    check("enr_chase", boss_state, 1);
    game_active = 2'b00;
    clks(1);
    check("idle_clr_enr", enraged, 0);
    check("idle_state", boss_state, 0);

    // Death coinciding with windup expiry
    game_active = 2'b01; boss_hp = 7'd100;
    ticks(2);
    check("d_windup", boss_state, 2);
    ticks(29);
    @(negedge clk);
    boss_hp = 7'd0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("dead", boss_state, 5);
    check("dead_no_start", attack_start, 0);
    check("dead_move", move_en, 0);
    boss_hp = 7'd100;
    tick();
    check("dead_sticky", boss_state, 5);
    game_active = 2'b10;
    clks(1);
    check("dead_to_idle", boss_state, 0);

    // Asynchronous reset mid-ATTACK
    game_active = 2'b01;
    ticks(2);
    ticks(30);
    check("pre_rst_attack", attack_active, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_state", boss_state, 0);
    check("arst_active", attack_active, 0);
    check("arst_tx", target_x, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_chase", boss_state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boss_ctrl.md
Name: boss_ctrl

Overview:
Boss behaviour sequencer between the player/aggro inputs and the boss movement and render datapath. It does three things:
- Picks which player the boss targets, with aggro hysteresis.
- Sequences the chase, wind-up, attack and cooldown phases on the 60 Hz frame tick.
- Flags enrage and death from boss HP.

Movement consumes move_en/target_x. Render and hit logic consume boss_state, attack_start and attack_active.

Parameters:
WINDUP_FRAMES, 30, frame ticks spent in WINDUP (not enraged)
ATTACK_FRAMES, 10, frame ticks spent in ATTACK
COOLDOWN_FRAMES, 60, frame ticks spent in COOLDOWN (not enraged)
ATTACK_RANGE, 150, max |boss_x - target_x| in pixels that triggers WINDUP
ENRAGE_HP, 30, enrage when 0 < boss_hp <= ENRAGE_HP
AGGRO_HYST, 2, aggro margin needed to switch target

Ports:
clk  in  1  system clock (65 MHz)
rst  in  1  asynchronous reset, active-low (asserted at 0)
frame_tick  in  1  one-clk pulse per frame
game_active  in  2  2'b01 = fight in progress; any other value = not fighting
boss_hp  in  7  current boss HP
boss_x  in  12  boss x position
char_x  in  12  player 1 x
player_2_x  in  12  player 2 x
class_aggro  in  4  player 1 aggro
player_2_aggro  in  4  player 2 aggro
player_2_data_valid  in  1  player 2 present/valid
target_sel  out  1  0 = player 1, 1 = player 2
target_x  out  12  x of the selected target
move_en  out  1  boss may move toward target_x
boss_state  out  3  IDLE=0, CHASE=1, WINDUP=2, ATTACK=3, COOLDOWN=4, DEAD=5
attack_start  out  1  one-clk pulse on entry to ATTACK
attack_active  out  1  high throughout ATTACK
enraged  out  1  enrage flag

Behaviour:
- Reset (rst=0, asynchronous): every output is 0 and boss_state=IDLE; frame counter=0.
- fight = (game_active==2'b01). Every transition below happens on a clk edge.
- Priority, highest first, evaluated every clk:
  - !fight → IDLE next clk from any state; counter and enraged cleared; target_sel held.
  - fight && boss_hp==0 && state!=IDLE → DEAD next clk. DEAD is sticky until !fight.
  - Otherwise, normal transitions. These advance only on clks where frame_tick=1.
- Normal transitions (all on frame_tick):
  - IDLE → CHASE when fight && boss_hp!=0.
  - CHASE: re-arbitrate the target first, then compute dist = |boss_x - target_x| as 12-bit unsigned using the new target. If dist <= ATTACK_RANGE → WINDUP, counter loaded.
  - WINDUP → ATTACK when its counter expires.
  - ATTACK → COOLDOWN after ATTACK_FRAMES ticks.
  - COOLDOWN → CHASE when its counter expires.
- Frame counter: 7-bit.
  - Loaded with N-1 on phase entry.
  - Decremented on each frame_tick; the phase exits on the tick where counter==0, so each phase lasts exactly N ticks.
  - N = WINDUP_FRAMES, ATTACK_FRAMES or COOLDOWN_FRAMES.
  - When enraged, WINDUP and COOLDOWN use N>>1, minimum 1. ATTACK is unchanged.
  - The enrage value is sampled at phase entry.
- Target arbitration (CHASE only, on frame_tick):
  - player_2_data_valid=0 → target_sel=0.
  - Else, switch to the other player when its aggro >= current target's aggro + AGGRO_HYST. Compute the sum in 5 bits; no wrap.
  - Ties and smaller margins keep the current target.
  - Target is frozen in WINDUP, ATTACK and COOLDOWN.
  - If player_2_data_valid drops while target_sel=1, force target_sel=0 on the next frame_tick, in any state.
- target_x is registered: char_x or player_2_x per target_sel, updated every clk.
- Outputs:
  - move_en = (state==CHASE), registered with the state.
  - attack_start asserts on the same clk the state becomes ATTACK, for exactly one clk.
  - attack_active = (state==ATTACK).
- enraged:
  - Set on any clk where fight && 0<boss_hp<=ENRAGE_HP.
  - Sticky; cleared only by reset or entry to IDLE.
- Simultaneous events:
  - hp→0 in the same clk as a phase expiry: DEAD wins and no attack_start is issued.
  - frame_tick coinciding with !fight: IDLE wins.

Test Plan:
1. Reset mid-ATTACK (rst=0) → all outputs 0 and boss_state=0 immediately (asynchronous); after release with fight, first frame_tick gives boss_state=1.
2. boss_x=400, char_x=500, p2 invalid, hp=100 → next tick WINDUP. attack_start pulses 1 clk after 30 ticks; attack_active high for exactly 10 ticks; CHASE again after 60 more ticks.
3. Aggro: target 0, class_aggro=5, player_2_aggro=6 → stays 0. Set player_2_aggro=7 → target_sel=1 on next CHASE tick and target_x=player_2_x. Same change during WINDUP → no switch until CHASE.
4. hp=30 → enraged=1; windup lasts 15 ticks, cooldown 30, attack still 10. Enter IDLE → enraged=0.
5. hp→0 during WINDUP → DEAD next clk, no attack_start, move_en=0. game_active=2'b10 → IDLE next clk.
6. target_sel=1, then player_2_data_valid=0 during COOLDOWN → target_sel=0 at next frame_tick. Distance check: boss_x=100, char_x=250 (dist=150) → WINDUP; char_x=251 → remains CHASE.
